// File: rtl/win_gen3_3.sv
// 3x3 sliding-window generator for a raster pixel stream.
//
// The block keeps two line buffers holding the previous two image rows and a
// 3x3 shift window. Every accepted pixel shifts the window left by one column
// and loads a new column {row r-2, row r-1, current pixel}. A window is emitted
// one cycle after each accepted pixel whose position is at or beyond (2, 2), so
// only fully populated windows are produced; border positions yield nothing.
//
// Ports
//   iclk   in   clock; all state updates on the rising edge
//   irst   in   synchronous active-high reset; overrides ien
//   ien    in   pixel-valid qualifier
//   idata  in   pixel, raster order
//   oen    out  window-valid strobe, one cycle per window
//   odata  out  3x3 window, row-major; [0] top-left, [8] newest pixel
//   oeof   out  marks the last window of a frame (only together with oen)
module win_gen3_3 #(
    parameter int pDATA_W = 8,
    parameter int pIMG_W  = 32,
    parameter int pIMG_H  = 32
) (
    input  logic                        iclk,
    input  logic                        irst,
    input  logic                        ien,
    input  logic [pDATA_W-1:0]          idata,
    output logic                        oen,
    output logic [8:0][pDATA_W-1:0]     odata,
    output logic                        oeof
);

    localparam int COL_W = $clog2(pIMG_W);
    localparam int ROW_W = $clog2(pIMG_H);

    // Line buffers: lb0 holds row r-2, lb1 holds row r-1. Not reset; windows
    // only start at row 2, by which time both rows have been rewritten.
    logic [pDATA_W-1:0]      r_lb0 [pIMG_W];
    logic [pDATA_W-1:0]      r_lb1 [pIMG_W];

    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [8:0][pDATA_W-1:0] r_win;
    logic                    r_oen;
    logic                    r_oeof;
    logic [8:0][pDATA_W-1:0] r_odata;

    logic [8:0][pDATA_W-1:0] w_win_nxt;
    logic                    w_last_col;
    logic                    w_last_row;
    logic                    w_emit;

    assign w_last_col = (r_col == COL_W'(pIMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(pIMG_H - 1));
    assign w_emit     = ien && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    // Shift each window row left and append the new column on the right.
    always_comb begin
        w_win_nxt    = r_win;
        w_win_nxt[0] = r_win[1];
        w_win_nxt[1] = r_win[2];
        w_win_nxt[2] = r_lb0[r_col];
        w_win_nxt[3] = r_win[4];
        w_win_nxt[4] = r_win[5];
        w_win_nxt[5] = r_lb1[r_col];
        w_win_nxt[6] = r_win[7];
        w_win_nxt[7] = r_win[8];
        w_win_nxt[8] = idata;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_oen   <= 1'b0;
            r_oeof  <= 1'b0;
            r_odata <= '0;
        end else begin
            r_oen  <= w_emit;
            r_oeof <= w_emit && w_last_col && w_last_row;
            if (ien) begin
                r_win <= w_win_nxt;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            // odata only changes on an emitted window so it holds otherwise.
            if (w_emit) begin
                r_odata <= w_win_nxt;
            end
        end
    end

    // Line buffer writes: the row moves from lb1 to lb0 as the new pixel lands.
    always_ff @(posedge iclk) begin
        if (!irst && ien) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= idata;
        end
    end

    assign oen   = r_oen;
    assign oeof  = r_oeof;
    assign odata = r_odata;

endmodule

// File: tb/tb_win_gen3_3.sv
// Scoreboard bench for win_gen3_3 on a 4x4 frame whose pixels equal their
// raster index. The driver pushes the hand-computed window right after the
// clock edge that accepts a window-producing pixel; the monitor, on the falling
// edge, requires oen exactly when an entry is pending and compares it.
module tb_win_gen3_3;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;

    logic                  iclk;
    logic                  irst;
    logic                  ien;
    logic [DW-1:0]         idata;
    logic                  oen;
    logic [8:0][DW-1:0]    odata;
    logic                  oeof;

    typedef struct packed {
        logic [8:0][DW-1:0] win;
        logic               eof;
        logic [7:0]         avg;
    } exp_t;

    exp_t               sb_q[$];
    int                 checks = 0;
    int                 passes = 0;
    logic               mon_en = 1'b0;
    logic               rst_seen = 1'b0;
    logic [8:0][DW-1:0] last_win = '0;

    // Hand-computed window offsets for a 4-wide image; windows start at
    // raster bases 0, 1, 4, 5. Downstream averages are sum/16.
    int offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int bases[4] = '{0, 1, 4, 5};
    int avgs [4] = '{2, 3, 5, 5};

    win_gen3_3 #(
        .pDATA_W(DW),
        .pIMG_W (IW),
        .pIMG_H (IH)
    ) dut (
        .iclk (iclk),
        .irst (irst),
        .ien  (ien),
        .idata(idata),
        .oen  (oen),
        .odata(odata),
        .oeof (oeof)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(posedge iclk) rst_seen = irst;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    function automatic exp_t make_exp(input int k);
        exp_t e;
        for (int i = 0; i < 9; i++) e.win[i] = DW'(bases[k] + offs[i]);
        e.eof = (k == 3);
        e.avg = 8'(avgs[k]);
        return e;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge iclk) begin
        if (mon_en) begin
            if (rst_seen) begin
                check("reset_oen", 128'(oen), 128'(0));
                check("reset_oeof", 128'(oeof), 128'(0));
                check("reset_odata", 128'(odata), 128'(0));
                last_win = '0;
            end else begin
                check("oen_timing", 128'(oen), 128'(sb_q.size() != 0));
                if (oen && sb_q.size() != 0) begin
                    exp_t e;
                    int   sum;
                    e = sb_q.pop_front();
                    check("window", 128'(odata), 128'(e.win));
                    check("eof", 128'(oeof), 128'(e.eof));
                    sum = 0;
                    for (int i = 0; i < 9; i++) sum += int'(odata[i]);
                    check("adder_avg", 128'(sum / 16), 128'(e.avg));
                    last_win = e.win;
                end else if (!oen) begin
                    check("oeof_idle", 128'(oeof), 128'(0));
                    check("odata_hold", 128'(odata), 128'(last_win));
                end
            end
        end
    end

    task automatic send(input int idx, input logic en);
        irst  = 1'b0;
        ien   = en;
        idata = DW'(idx);
        @(posedge iclk);
        if (en) begin
            case (idx)
                10: sb_q.push_back(make_exp(0));
                11: sb_q.push_back(make_exp(1));
                14: sb_q.push_back(make_exp(2));
                15: sb_q.push_back(make_exp(3));
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic frame(input logic gaps);
        for (int i = 0; i < IW * IH; i++) begin
            send(i, 1'b1);
            if (gaps) send(0, 1'b0);
        end
    endtask

    task automatic do_reset(input int cycles, input logic en);
        irst  = 1'b1;
        ien   = en;
        idata = 8'd99;
        repeat (cycles) @(posedge iclk);
        #1;
        irst = 1'b0;
        ien  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 1'b0);
    endtask

    initial begin
        irst  = 1'b1;
        ien   = 1'b0;
        idata = '0;
        repeat (2) @(posedge iclk);
        #1;
        mon_en = 1'b1;
        do_reset(1, 1'b0);

        // Continuous frame.
        frame(1'b0);
        idle(3);
        // Same frame with ien low every other cycle.
        frame(1'b1);
        idle(3);
        // Two frames back-to-back with no idle between them.
        frame(1'b0);
        frame(1'b0);
        idle(3);
        // Reset mid-frame after index 9, then a fresh frame.
        for (int i = 0; i < 10; i++) send(i, 1'b1);
        do_reset(2, 1'b0);
        frame(1'b0);
        idle(3);
        // Reset together with ien: the presented pixel must be dropped.
        do_reset(1, 1'b1);
        frame(1'b0);
        idle(3);

        check("queue_drained", 128'(sb_q.size()), 128'(0));
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
